gal_olmc_bank: RTL

Parametrised, cycle-accurate model of a bank of N GAL output logic macrocells, the simulation and FPGA-emulation counterpart of the `GAL_OLMC` primitive that technology mapping emits. Each cell is independently configured as registered or combinational and as active-high or inverted. Registered cells support synchronous reset, synchronous preset and register preload. The bank sits between the mapped product-term array and the device pins, and returns per-cell feedback to the array.

---
 rtl/gal_pkg.sv | 17 +
 rtl/gal_olmc_cell.sv | 61 ++++++
 rtl/gal_olmc_bank.sv | 42 ++++
 3 files changed

// File: rtl/gal_pkg.sv
// Shared constants and types for the GAL output macrocell bank.
package gal_pkg;

  // Largest macrocell count found on the supported GAL families.
  localparam int GAL_MAX_OLMC = 10;

  // Macrocell output mode: straight through or via the D flip-flop.
  typedef enum logic {
    OLMC_COMB = 1'b0,
    OLMC_REG  = 1'b1
  } olmc_mode_t;

  // Pin polarity: active-low means the pin drives the complement.
  localparam logic OLMC_ACT_HIGH = 1'b0;
  localparam logic OLMC_ACT_LOW  = 1'b1;

endpackage

// File: rtl/gal_olmc_cell.sv
// One GAL output logic macrocell: optional priority register plus output mux.
module gal_olmc_cell
  import gal_pkg::*;
#(
  parameter bit REGISTERED = 1'b1,
  parameter bit INVERTED   = 1'b0
) (
  input  logic clk,
  input  logic r,
  input  logic sp,
  input  logic pl,
  input  logic pld,
  input  logic a,
  input  logic e,
  output logic y,
  output logic ye,
  output logic fb
);

  localparam olmc_mode_t MODE = REGISTERED ? OLMC_REG : OLMC_COMB;

  generate
    if (MODE == OLMC_REG) begin : g_reg
      logic q_d;
      logic q_q;

      // Next state below reset: preload beats preset beats the sum term.
      always_comb begin
        q_d = a;
        if (pl) begin
          q_d = pld;
        end else if (sp) begin
          q_d = 1'b1;
        end
      end

      // Cell register; reset overrides every other source at the edge.
      always_ff @(posedge clk) begin
        if (r) begin
          q_q <= 1'b0;
        end else begin
          q_q <= q_d;
        end
      end

      // Feedback sees the true register state, the pin sees the polarity.
      assign y  = q_q ^ INVERTED;
      assign fb = q_q;
    end else begin : g_comb
      // Combinational cells have no register, so the control inputs are dead.
      logic unused_ctrl;
      assign unused_ctrl = ^{clk, r, sp, pl, pld};

      assign y  = a ^ INVERTED;
      assign fb = y;
    end
  endgenerate

  assign ye = e;

endmodule

// File: rtl/gal_olmc_bank.sv
// Bank of N GAL output macrocells between the product-term array and the pins.
module gal_olmc_bank
  import gal_pkg::*;
#(
  parameter int           N          = 8,
  parameter logic [N-1:0] REGISTERED = {N{1'(OLMC_REG)}},
  parameter logic [N-1:0] INVERTED   = {N{OLMC_ACT_HIGH}}
) (
  input  logic         C,
  input  logic         R,
  input  logic         SP,
  input  logic         PL,
  input  logic [N-1:0] PLD,
  input  logic [N-1:0] A,
  input  logic [N-1:0] E,
  output logic [N-1:0] Y,
  output logic [N-1:0] YE,
  output logic [N-1:0] FB
);

  // Strobes are broadcast; per-cell data and outputs are sliced by index.
  generate
    for (genvar i = 0; i < N; i++) begin : g_cell
      gal_olmc_cell #(
        .REGISTERED (REGISTERED[i]),
        .INVERTED   (INVERTED[i])
      ) u_cell (
        .clk (C),
        .r   (R),
        .sp  (SP),
        .pl  (PL),
        .pld (PLD[i]),
        .a   (A[i]),
        .e   (E[i]),
        .y   (Y[i]),
        .ye  (YE[i]),
        .fb  (FB[i])
      );
    end
  endgenerate

endmodule
